// File: rtl/picoblaze_port_bridge.sv
// PicoBlaze input-port bridge: captures N_CH peripheral words into holding registers
// and serves them through a registered in_port mux with read-to-clear and overrun tracking.
module picoblaze_port_bridge #(
  parameter int         N_CH    = 3,
  parameter logic [7:0] BASE_ID = 8'h05
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        port_id,
  input  logic              read_strobe,
  input  logic              write_strobe,
  input  logic [7:0]        out_port,
  input  logic [8*N_CH-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_valid,
  output logic [7:0]        in_port,
  output logic [N_CH-1:0]   rd_ack,
  output logic              interrupt
);

  localparam logic [7:0] STATUS_ID  = BASE_ID + 8'(N_CH);
  localparam logic [7:0] OVERRUN_ID = BASE_ID + 8'(N_CH + 1);

  logic [7:0]      hold [N_CH];
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] overrun;
  logic [N_CH-1:0] cap_last;
  logic [N_CH-1:0] rd_hit;
  logic [N_CH-1:0] w1c;
  logic [N_CH-1:0] new_ovr;
  logic [7:0]      status_word;
  logic [7:0]      overrun_word;
  logic [7:0]      mux_data;

  always_comb begin
    rd_hit       = '0;
    w1c          = '0;
    status_word  = 8'h00;
    overrun_word = 8'h00;
    mux_data     = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      rd_hit[i]       = read_strobe && (port_id == BASE_ID + 8'(i));
      w1c[i]          = write_strobe && (port_id == OVERRUN_ID) && out_port[i];
      status_word[i]  = pending[i];
      overrun_word[i] = overrun[i];
      if (port_id == BASE_ID + 8'(i))
        mux_data = hold[i];
    end
    if (port_id == STATUS_ID)
      mux_data = status_word;
    if (port_id == OVERRUN_ID)
      mux_data = overrun_word;
  end

  // A read consumes the word, so a capture racing it is not an overrun.
  assign new_ovr = ch_valid & pending & ~rd_hit;

  // A word captured in the cycle in_port was loaded, or during the read itself,
  // was never seen by the processor, so pending must survive the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++)
        hold[i] <= 8'h00;
      pending   <= '0;
      overrun   <= '0;
      cap_last  <= '0;
      in_port   <= 8'h00;
      rd_ack    <= '0;
      interrupt <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (ch_valid[i])
          hold[i] <= ch_data[8*i +: 8];
      pending   <= ch_valid | (pending & ~(rd_hit & ~cap_last));
      overrun   <= (overrun & ~w1c) | new_ovr;
      cap_last  <= ch_valid;
      in_port   <= mux_data;
      rd_ack    <= rd_hit;
      interrupt <= |pending;
    end
  end

endmodule

// File: tb/tb_picoblaze_port_bridge.sv
// Scoreboard bench for picoblaze_port_bridge: a 3-channel instance at 05..09 and
// an 8-channel instance at 40..49 share the PicoBlaze bus.
module tb_picoblaze_port_bridge;

  localparam int K_IN  = 0;
  localparam int K_ACK = 1;
  localparam int K_INT = 2;

  typedef struct {
    int         cyc;
    int         dut;
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id;
  logic        read_strobe;
  logic        write_strobe;
  logic [7:0]  out_port;
  logic [23:0] a_data;
  logic [2:0]  a_valid;
  logic [7:0]  a_in_port;
  logic [2:0]  a_rd_ack;
  logic        a_int;
  logic [63:0] b_data;
  logic [7:0]  b_valid;
  logic [7:0]  b_in_port;
  logic [7:0]  b_rd_ack;
  logic        b_int;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  picoblaze_port_bridge #(.N_CH(3), .BASE_ID(8'h05)) dut_a (
    .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .out_port(out_port), .ch_data(a_data),
    .ch_valid(a_valid), .in_port(a_in_port), .rd_ack(a_rd_ack), .interrupt(a_int)
  );

  picoblaze_port_bridge #(.N_CH(8), .BASE_ID(8'h40)) dut_b (
    .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .out_port(out_port), .ch_data(b_data),
    .ch_valid(b_valid), .in_port(b_in_port), .rd_ack(b_rd_ack), .interrupt(b_int)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(int dut, int kind);
    logic [7:0] r;
    r = 8'h00;
    if (dut == 0) begin
      case (kind)
        K_IN:    r = a_in_port;
        K_ACK:   r = {5'b0, a_rd_ack};
        default: r = {7'b0, a_int};
      endcase
    end else begin
      case (kind)
        K_IN:    r = b_in_port;
        K_ACK:   r = b_rd_ack;
        default: r = {7'b0, b_int};
      endcase
    end
    return r;
  endfunction

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc <= cyc) begin
        logic [7:0] got;
        got = actual(sb[j].dut, sb[j].kind);
        checks++;
        if (sb[j].cyc != cyc || got !== sb[j].val) begin
          errors++;
          $display("[TB] FAIL %s: got %02h expected %02h (cycle %0d)",
                   sb[j].name, got, sb[j].val, cyc);
        end
        sb.delete(j);
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] pid, input logic rs, input logic ws,
                                input logic [7:0] op, input logic [2:0] av,
                                input logic [23:0] ad);
    port_id      = pid;
    read_strobe  = rs;
    write_strobe = ws;
    out_port     = op;
    a_valid      = av;
    a_data       = ad;
    b_valid      = 8'h00;
    b_data       = 64'h0;
  endtask

  task automatic check_output(input int dut, input int kind, input int lag,
                              input logic [7:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + lag;
    e.dut  = dut;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] mask;

    // Reset holds everything clear even with captures asserted.
    reset = 1'b1;
    apply_stimulus(8'h05, 0, 0, 8'h00, 3'b111, 24'hFFFFFF);
    b_valid = 8'hFF; b_data = '1;
    check_output(0, K_IN, 1, 8'h00, "rst_in0");
    check_output(0, K_ACK, 1, 8'h00, "rst_ack0");
    check_output(0, K_INT, 1, 8'h00, "rst_int0");
    tick();
    apply_stimulus(8'h05, 1, 0, 8'h00, 3'b111, 24'hFFFFFF);
    check_output(0, K_IN, 1, 8'h00, "rst_in1");
    check_output(0, K_ACK, 1, 8'h00, "rst_ack1");
    tick();
    reset = 1'b0;
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "status_after_rst");
    check_output(0, K_INT, 1, 8'h00, "int_after_rst");
    check_output(1, K_INT, 1, 8'h00, "b_int_after_rst");
    tick();
    apply_stimulus(8'h05, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "hold0_after_rst");
    tick();

    // Basic capture and read-to-clear on channel 1.
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b010, 24'h001C00);
    check_output(0, K_INT, 1, 8'h00, "int_lags_capture");
    tick();
    apply_stimulus(8'h06, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h1C, "basic_in_pre");
    check_output(0, K_INT, 1, 8'h01, "basic_int_set");
    tick();
    apply_stimulus(8'h06, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h1C, "basic_in_read");
    check_output(0, K_ACK, 1, 8'h02, "basic_ack");
    check_output(0, K_INT, 1, 8'h01, "basic_int_hold");
    tick();
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "basic_status_clr");
    check_output(0, K_ACK, 1, 8'h00, "basic_ack_one_cycle");
    check_output(0, K_INT, 1, 8'h00, "basic_int_fall");
    tick();

    // Unmapped address.
    apply_stimulus(8'h20, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "unmapped_in");
    check_output(0, K_ACK, 1, 8'h00, "unmapped_ack");
    check_output(1, K_ACK, 1, 8'h00, "b_unmapped_ack");
    tick();

    // Overrun on channel 0, then W1C.
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b001, 24'h0000AA);
    tick();
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b001, 24'h000055);
    tick();
    apply_stimulus(8'h05, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h55, "ovr_hold0");
    tick();
    apply_stimulus(8'h08, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h01, "ovr_status");
    check_output(0, K_ACK, 1, 8'h00, "status_read_no_ack");
    tick();
    apply_stimulus(8'h09, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h01, "ovr_overrun");
    tick();
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h01, "status_not_cleared");
    tick();
    apply_stimulus(8'h09, 0, 1, 8'h01, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h01, "w1c_cycle");
    tick();
    apply_stimulus(8'h09, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "w1c_cleared");
    tick();

    // W1C coincident with a new overrun: the new overrun wins.
    apply_stimulus(8'h09, 0, 1, 8'h01, 3'b001, 24'h000066);
    check_output(0, K_IN, 1, 8'h00, "race_w1c_cycle");
    tick();
    apply_stimulus(8'h08, 0, 1, 8'hFF, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h01, "status_during_write");
    tick();
    apply_stimulus(8'h09, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h01, "w1c_race_new_wins");
    tick();
    apply_stimulus(8'h09, 0, 1, 8'h01, 3'b000, 24'h0);
    tick();
    apply_stimulus(8'h09, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "ovr_cleared_again");
    tick();
    apply_stimulus(8'h05, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h66, "read_ch0");
    check_output(0, K_ACK, 1, 8'h01, "ack_ch0");
    tick();
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "status_ch0_clr");
    tick();

    // Capture one cycle before the read strobe keeps pending set.
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b100, 24'h330000);
    tick();
    apply_stimulus(8'h07, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h33, "ch2_first");
    tick();
    apply_stimulus(8'h07, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_ACK, 1, 8'h04, "ch2_first_ack");
    tick();
    apply_stimulus(8'h07, 0, 0, 8'h00, 3'b100, 24'h7E0000);
    check_output(0, K_IN, 1, 8'h33, "race_old_value");
    tick();
    apply_stimulus(8'h07, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h7E, "race_read_in");
    check_output(0, K_ACK, 1, 8'h04, "race_read_ack");
    tick();
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h04, "race_pending_kept");
    tick();
    apply_stimulus(8'h07, 0, 0, 8'h00, 3'b000, 24'h0);
    tick();
    apply_stimulus(8'h07, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h7E, "race_second_read");
    check_output(0, K_ACK, 1, 8'h04, "race_second_ack");
    tick();
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "race_cleared");
    tick();

    // Capture in the same cycle as the read strobe: pending kept, no overrun.
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b100, 24'h110000);
    tick();
    apply_stimulus(8'h07, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h11, "same_pre");
    tick();
    apply_stimulus(8'h07, 1, 0, 8'h00, 3'b100, 24'h440000);
    check_output(0, K_IN, 1, 8'h11, "same_read_in");
    check_output(0, K_ACK, 1, 8'h04, "same_read_ack");
    tick();
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h04, "same_pending_kept");
    tick();
    apply_stimulus(8'h09, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "same_no_overrun");
    tick();
    apply_stimulus(8'h07, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h44, "same_new_word");
    tick();
    apply_stimulus(8'h08, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(0, K_IN, 1, 8'h00, "same_cleared");
    tick();

    // 8-channel instance: capture all, clear one at a time.
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b000, 24'h0);
    b_valid = 8'hFF; b_data = 64'h1716151413121110;
    tick();
    apply_stimulus(8'h48, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(1, K_IN, 1, 8'hFF, "b_status_all");
    check_output(1, K_INT, 1, 8'h01, "b_int_set");
    tick();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'h40 + 8'(i), 1, 0, 8'h00, 3'b000, 24'h0);
      check_output(1, K_IN, 1, 8'h10 + 8'(i), "b_read");
      check_output(1, K_ACK, 1, 8'h01 << i, "b_ack");
      tick();
      mask = 8'hFF;
      mask = mask << (i + 1);
      apply_stimulus(8'h48, 0, 0, 8'h00, 3'b000, 24'h0);
      check_output(1, K_IN, 1, mask, "b_status_step");
      tick();
    end
    apply_stimulus(8'h49, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(1, K_INT, 1, 8'h00, "b_int_clear");
    tick();

    // 8-channel overrun on channel 7 with masked W1C.
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b000, 24'h0);
    b_valid = 8'h80; b_data = 64'hAB00000000000000;
    tick();
    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b000, 24'h0);
    b_valid = 8'h80; b_data = 64'hCD00000000000000;
    tick();
    apply_stimulus(8'h49, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(1, K_IN, 1, 8'h80, "b_overrun7");
    tick();
    apply_stimulus(8'h49, 0, 1, 8'h7F, 3'b000, 24'h0);
    tick();
    apply_stimulus(8'h49, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(1, K_IN, 1, 8'h80, "b_w1c_masked");
    tick();
    apply_stimulus(8'h49, 0, 1, 8'h80, 3'b000, 24'h0);
    tick();
    apply_stimulus(8'h49, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(1, K_IN, 1, 8'h00, "b_w1c_clear");
    tick();
    apply_stimulus(8'h47, 1, 0, 8'h00, 3'b000, 24'h0);
    check_output(1, K_IN, 1, 8'hCD, "b_read7");
    check_output(1, K_ACK, 1, 8'h80, "b_ack7");
    tick();
    apply_stimulus(8'h48, 0, 0, 8'h00, 3'b000, 24'h0);
    check_output(1, K_IN, 1, 8'h00, "b_status_final");
    tick();

    apply_stimulus(8'h20, 0, 0, 8'h00, 3'b000, 24'h0);
    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
